// File: rtl/vote_uart_tx.sv
// vote_uart_tx: snapshots four 4-bit vote counts on send and emits them as an 8N1 UART frame
// (HEADER, A, B, C, D[, XOR checksum]); uart_tx/busy go active the cycle after send is sampled.
// send is ignored while busy (no queueing); optional checksum byte enabled by `VOTE_UART_CHECKSUM_EN.
module vote_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [3:0] votecounta,
    input  logic [3:0] votecountb,
    input  logic [3:0] votecountc,
    input  logic [3:0] votecountd,
    output logic       uart_tx,
    output logic       busy,
    output logic       done
);

`ifdef VOTE_UART_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd5;
`else
    localparam logic [2:0] LAST_BYTE = 3'd4;
`endif
    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [2:0]  byte_idx;
    logic [3:0]  snap_a;
    logic [3:0]  snap_b;
    logic [3:0]  snap_c;
    logic [3:0]  snap_d;
    logic [7:0]  cur_byte;
    logic [2:0]  next_bit;
    logic        baud_end;

    assign baud_end = (baud_cnt == BAUD_MAX);
    assign next_bit = bit_idx + 3'd1;

    // Pick the frame byte currently being serialised from the latched snapshot
    always_comb begin
        cur_byte = HEADER;
        case (byte_idx)
            3'd1:    cur_byte = {4'h0, snap_a};
            3'd2:    cur_byte = {4'h0, snap_b};
            3'd3:    cur_byte = {4'h0, snap_c};
            3'd4:    cur_byte = {4'h0, snap_d};
`ifdef VOTE_UART_CHECKSUM_EN
            3'd5:    cur_byte = HEADER ^ {4'h0, snap_a ^ snap_b ^ snap_c ^ snap_d};
`endif
            default: cur_byte = HEADER;
        endcase
    end

    // Frame FSM: every line level is held for CLKS_PER_BIT cycles; outputs are registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            snap_a   <= 4'd0;
            snap_b   <= 4'd0;
            snap_c   <= 4'd0;
            snap_d   <= 4'd0;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    uart_tx  <= 1'b1;
                    baud_cnt <= 16'd0;
                    bit_idx  <= 3'd0;
                    byte_idx <= 3'd0;
                    if (send) begin
                        snap_a  <= votecounta;
                        snap_b  <= votecountb;
                        snap_c  <= votecountc;
                        snap_d  <= votecountd;
                        uart_tx <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= 16'd0;
                        bit_idx  <= 3'd0;
                        uart_tx  <= cur_byte[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= next_bit;
                            uart_tx <= cur_byte[next_bit];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= 16'd0;
                        if (byte_idx == LAST_BYTE) begin
                            byte_idx <= 3'd0;
                            uart_tx  <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            uart_tx  <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
